// File: rtl/nes_sram_arbiter.sv
// Shares one 16-bit asynchronous SRAM between the CPU and PPU byte channels.
// Each granted request runs through SETUP, a timed ACCESS phase and a DONE cycle that returns the ack.
module nes_sram_arbiter #(
  parameter int unsigned access_cycles = 2,
  parameter logic        ppu_priority  = 1'b1
) (
  input  logic        dual_clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [19:0] cpu_addr,
  input  logic        cpu_we_n,
  input  logic        cpu_oe_n,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_req,
  input  logic [19:0] ppu_addr,
  input  logic        ppu_we_n,
  input  logic        ppu_oe_n,
  input  logic [7:0]  ppu_wdata,
  output logic        ppu_ack,
  output logic [7:0]  ppu_rdata,
  output logic [18:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        grant_ppu;
  logic        last_grant_ppu;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        read_q;
  logic        any_req;
  logic        pick_ppu;
  logic        pick_we_n;
  logic        pick_oe_n;
  logic        last_access;
  logic [7:0]  read_byte;

  // On a tie the channel that did not win last time goes next, so neither side starves.
  always_comb begin
    any_req   = cpu_req | ppu_req;
    pick_ppu  = (cpu_req && ppu_req) ? !last_grant_ppu : ppu_req;
    pick_we_n = pick_ppu ? ppu_we_n : cpu_we_n;
    pick_oe_n = pick_ppu ? ppu_oe_n : cpu_oe_n;
    last_access = (count == 4'(access_cycles - 1));
    read_byte = addr_q[0] ? sram_dq_in[15:8] : sram_dq_in[7:0];
  end

  always_ff @(posedge dual_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    cpu_ack    = 1'b0;
    ppu_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = (pick_we_n && pick_oe_n) ? DONE : SETUP;
      end
      SETUP: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = !addr_q[0];
        sram_lb_n  = addr_q[0];
        sram_dq_oe = write_q;
        state_next = ACCESS;
      end
      ACCESS: begin
        sram_ce_n  = 1'b0;
        sram_ub_n  = !addr_q[0];
        sram_lb_n  = addr_q[0];
        sram_dq_oe = write_q;
        sram_we_n  = !write_q;
        sram_oe_n  = !read_q;
        if (last_access) state_next = DONE;
      end
      DONE: begin
        cpu_ack    = !grant_ppu;
        ppu_ack    = grant_ppu;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign sram_addr   = addr_q[19:1];
  assign sram_dq_out = {wdata_q, wdata_q};

  // Requester fields are captured once at grant; a write wins if both enables are low.
  always_ff @(posedge dual_clock or posedge reset) begin
    if (reset) begin
      grant_ppu      <= 1'b0;
      last_grant_ppu <= !ppu_priority;
      addr_q         <= '0;
      wdata_q        <= '0;
      write_q        <= 1'b0;
      read_q         <= 1'b0;
      count          <= '0;
      cpu_rdata      <= '0;
      ppu_rdata      <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_ppu      <= pick_ppu;
        last_grant_ppu <= pick_ppu;
        addr_q         <= pick_ppu ? ppu_addr : cpu_addr;
        wdata_q        <= pick_ppu ? ppu_wdata : cpu_wdata;
        write_q        <= !pick_we_n;
        read_q         <= pick_we_n && !pick_oe_n;
      end
      if (state == ACCESS && !last_access) count <= count + 4'd1;
      else                                 count <= '0;
      if (state == ACCESS && last_access && read_q) begin
        if (grant_ppu) ppu_rdata <= read_byte;
        else           cpu_rdata <= read_byte;
      end
    end
  end

endmodule

// File: tb/tb_nes_sram_arbiter.sv
// Directed bench for nes_sram_arbiter: a driver checks SRAM strobe timing while a
// monitor matches every ack against a queue of expected channel/read-data pairs.
module tb_nes_sram_arbiter;

  localparam int AC = 2;

  logic        dual_clock = 1'b0;
  logic        reset;
  logic        cpu_req = 1'b0, ppu_req = 1'b0;
  logic [19:0] cpu_addr = '0, ppu_addr = '0;
  logic        cpu_we_n = 1'b1, cpu_oe_n = 1'b1, ppu_we_n = 1'b1, ppu_oe_n = 1'b1;
  logic [7:0]  cpu_wdata = '0, ppu_wdata = '0;
  logic        cpu_ack, ppu_ack;
  logic [7:0]  cpu_rdata, ppu_rdata;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_in = '0;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  typedef struct {
    logic       chan;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  nes_sram_arbiter #(.access_cycles(AC), .ppu_priority(1'b1)) dut (
    .dual_clock(dual_clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we_n(cpu_we_n), .cpu_oe_n(cpu_oe_n),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_we_n(ppu_we_n), .ppu_oe_n(ppu_oe_n),
    .ppu_wdata(ppu_wdata), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 dual_clock = ~dual_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge dual_clock);
      if (cpu_ack || ppu_ack) begin
        checkOutput("ack_exclusive", 32'(cpu_ack && ppu_ack), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: cpu_ack=%0b ppu_ack=%0b with no pending request", cpu_ack, ppu_ack);
        end else begin
          e = sb_q.pop_front();
          checkOutput("ack_channel", 32'(ppu_ack), 32'(e.chan));
          checkOutput("ack_rdata", 32'(ppu_ack ? ppu_rdata : cpu_rdata), 32'(e.rdata));
        end
      end
    end
  end

  // Issues one request (called at a negedge) and checks the strobe sequence cycle by cycle.
  task automatic applyStimulus(input logic chan, input logic [19:0] addr, input logic we_n,
                               input logic oe_n, input logic [7:0] wdata, input logic [7:0] exp_rdata);
    logic wr, rd;
    wr = !we_n;
    rd = we_n && !oe_n;
    if (chan) begin
      ppu_addr = addr; ppu_we_n = we_n; ppu_oe_n = oe_n; ppu_wdata = wdata; ppu_req = 1'b1;
    end else begin
      cpu_addr = addr; cpu_we_n = we_n; cpu_oe_n = oe_n; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    sb_q.push_back('{chan, exp_rdata});
    @(posedge dual_clock);
    @(negedge dual_clock);
    if (!wr && !rd) begin
      checkOutput("noop_ack", 32'(chan ? ppu_ack : cpu_ack), 32'd1);
      checkOutput("noop_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
    end else begin
      checkOutput("setup_addr", 32'(sram_addr), 32'(addr[19:1]));
      checkOutput("setup_ce_oe_we", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h3);
      checkOutput("setup_lanes", {30'd0, sram_ub_n, sram_lb_n}, {30'd0, !addr[0], addr[0]});
      checkOutput("setup_dq_oe", 32'(sram_dq_oe), 32'(wr));
      if (wr) checkOutput("setup_dq_out", 32'(sram_dq_out), {16'd0, wdata, wdata});
      for (int i = 0; i < AC; i++) begin
        @(negedge dual_clock);
        checkOutput("access_oe_n", 32'(sram_oe_n), 32'(!rd));
        checkOutput("access_we_n", 32'(sram_we_n), 32'(!wr));
        checkOutput("access_dq_oe", 32'(sram_dq_oe), 32'(wr));
        checkOutput("access_addr_ce", {12'd0, sram_addr, sram_ce_n}, {12'd0, addr[19:1], 1'b0});
        checkOutput("access_no_ack", 32'(cpu_ack | ppu_ack), 32'd0);
      end
      @(negedge dual_clock);
      checkOutput("done_ack", 32'(chan ? ppu_ack : cpu_ack), 32'd1);
      checkOutput("done_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
    end
    if (chan) ppu_req = 1'b0;
    else      cpu_req = 1'b0;
  endtask

  initial begin
    int acks;
    reset = 1'b1;
    #3;
    checkOutput("reset_strobes", {25'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, 1'b0}, 32'h7C);
    checkOutput("reset_addr_dq", {sram_addr, 13'd0} | 32'(sram_dq_out), 32'd0);
    checkOutput("reset_acks_rdata", {14'd0, cpu_ack, ppu_ack, cpu_rdata, ppu_rdata}, 32'd0);
    @(negedge dual_clock);
    reset = 1'b0;

    // Both channels request from reset: PPU, CPU, PPU, CPU.
    sram_dq_in = 16'hC33C;
    cpu_addr = 20'h00010; cpu_we_n = 1'b1; cpu_oe_n = 1'b0;
    ppu_addr = 20'h00021; ppu_we_n = 1'b1; ppu_oe_n = 1'b0;
    sb_q.push_back('{1'b1, 8'hC3});
    sb_q.push_back('{1'b0, 8'h3C});
    sb_q.push_back('{1'b1, 8'hC3});
    sb_q.push_back('{1'b0, 8'h3C});
    cpu_req = 1'b1; ppu_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge dual_clock);
      if (cpu_ack || ppu_ack) acks++;
    end
    cpu_req = 1'b0; ppu_req = 1'b0;
    checkOutput("tie_ack_count", 32'(acks), 32'd4);
    repeat (3) @(negedge dual_clock);

    sram_dq_in = 16'hA55A;
    applyStimulus(1'b0, 20'h04001, 1'b1, 1'b0, 8'h00, 8'hA5);
    @(negedge dual_clock);
    applyStimulus(1'b1, 20'h00000, 1'b0, 1'b1, 8'h10, 8'hC3);
    @(negedge dual_clock);
    applyStimulus(1'b0, 20'h12345, 1'b1, 1'b1, 8'h77, 8'hA5);
    @(negedge dual_clock);

    // Reset in the middle of a write aborts it; the held request is then redone.
    cpu_addr = 20'h00102; cpu_we_n = 1'b0; cpu_oe_n = 1'b1; cpu_wdata = 8'h5E; cpu_req = 1'b1;
    @(posedge dual_clock);
    @(negedge dual_clock);
    @(negedge dual_clock);
    checkOutput("pre_reset_we_n", 32'(sram_we_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_strobes", {29'd0, sram_we_n, sram_ce_n, sram_dq_oe}, 32'h6);
    checkOutput("abort_rdata", 32'(cpu_rdata), 32'd0);
    repeat (2) begin
      @(negedge dual_clock);
      checkOutput("abort_no_ack", 32'(cpu_ack | ppu_ack), 32'd0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 20'h00102, 1'b0, 1'b1, 8'h5E, 8'h00);
    repeat (3) @(negedge dual_clock);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
